deserializer: RTL and testbench

Serial-to-parallel receiver; the receive-side counterpart of the team's serializer. Collects a contiguous burst of serial bits (MSB first, one bit per clock while valid is high) into a parallel word, then emits the word with a bit count and a one-cycle valid pulse. It sits at the far end of the serial link and feeds parallel consumers.

---
 rtl/serdes_pkg.sv | 13 +
 rtl/deserializer.sv | 111 +++++++++++
 tb/tb_deserializer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Types and constants shared by both ends of the serial link.
// The serializer uses the same minimum burst length.
package serdes_pkg;

  typedef enum logic {
    IDLE_S = 1'b0,
    RECV_S = 1'b1
  } state_t;

  // Shortest legal burst; 1- and 2-bit bursts are dropped by the receiver.
  localparam int MIN_BURST_LEN = 3;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: collects MSB-first bursts into MSB-aligned words
// and emits each word with its bit count and a one-cycle data_val_o pulse.
module deserializer
  import serdes_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] data_o,
  output logic [DATA_MOD_WIDTH-1:0] data_mod_o,
  output logic                      data_val_o,
  output logic                      busy_o
);

  // Valid semantics: ser_data_i is consumed on every edge where
  // ser_data_val_i=1; data_val_o is a single-cycle pulse with no ready, so the
  // consumer must take data_o/data_mod_o in exactly that cycle.

  localparam logic [DATA_MOD_WIDTH-1:0] LAST_CNT = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1);
  localparam logic [DATA_MOD_WIDTH-1:0] MIN_CNT  = DATA_MOD_WIDTH'(MIN_BURST_LEN);

  state_t                    state;
  state_t                    state_nxt;
  logic [DATA_BUS_WIDTH-1:0] sh;
  logic [DATA_BUS_WIDTH-1:0] sh_nxt;
  logic [DATA_MOD_WIDTH-1:0] cnt;
  logic [DATA_MOD_WIDTH-1:0] cnt_nxt;
  logic [DATA_BUS_WIDTH-1:0] data_nxt;
  logic [DATA_MOD_WIDTH-1:0] mod_nxt;
  logic                      val_nxt;
  logic [DATA_BUS_WIDTH-1:0] in_word;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state      <= IDLE_S;
      sh         <= '0;
      cnt        <= '0;
      data_o     <= '0;
      data_mod_o <= '0;
      data_val_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      sh         <= sh_nxt;
      cnt        <= cnt_nxt;
      data_o     <= data_nxt;
      data_mod_o <= mod_nxt;
      data_val_o <= val_nxt;
    end
  end

  // Incoming bit placed at position DATA_BUS_WIDTH-1-cnt; lower bits of sh
  // are still zero, so OR-ing it in also serves the final bit at position 0.
  always_comb begin
    in_word = {ser_data_i, {(DATA_BUS_WIDTH-1){1'b0}}} >> cnt;
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    data_nxt  = data_o;
    mod_nxt   = data_mod_o;
    val_nxt   = 1'b0;
    case (state)
      IDLE_S: begin
        if (ser_data_val_i) begin
          sh_nxt    = {ser_data_i, {(DATA_BUS_WIDTH-1){1'b0}}};
          cnt_nxt   = DATA_MOD_WIDTH'(1);
          state_nxt = RECV_S;
        end
      end
      RECV_S: begin
        if (ser_data_val_i) begin
          if (cnt == LAST_CNT) begin
            data_nxt  = sh | in_word;
            mod_nxt   = '0;
            val_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE_S;
          end else begin
            sh_nxt  = sh | in_word;
            cnt_nxt = cnt + DATA_MOD_WIDTH'(1);
          end
        end else begin
          if (cnt >= MIN_CNT) begin
            data_nxt = sh;
            mod_nxt  = cnt;
            val_nxt  = 1'b1;
          end
          cnt_nxt   = '0;
          state_nxt = IDLE_S;
        end
      end
      default: begin
        state_nxt = IDLE_S;
        sh_nxt    = 'x;
        cnt_nxt   = 'x;
        data_nxt  = 'x;
        mod_nxt   = 'x;
        val_nxt   = 1'bx;
      end
    endcase
  end

  assign busy_o = (state == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: directed bursts from the test plan plus random
// bursts, checked cycle by cycle against a queue-based burst model.
module tb_deserializer;

  localparam int W  = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          srst_i = 1'b0;
  logic          ser_data_i = 1'b0;
  logic          ser_data_val_i = 1'b0;
  logic [W-1:0]  data_o;
  logic [MW-1:0] data_mod_o;
  logic          data_val_o;
  logic          busy_o;

  int errors = 0;
  int checks = 0;

  // Model state: bits of the word currently being received, and the
  // expected view of the outputs after each edge.
  bit                 q_bits[$];
  logic [W+MW-1:0]    exp_q[$];
  logic [W-1:0]       exp_data = '0;
  logic [MW-1:0]      exp_mod  = '0;
  bit                 exp_val  = 1'b0;
  bit                 exp_busy = 1'b0;

  deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW)) dut (
    .clk_i          (clk),
    .srst_i         (srst_i),
    .ser_data_i     (ser_data_i),
    .ser_data_val_i (ser_data_val_i),
    .data_o         (data_o),
    .data_mod_o     (data_mod_o),
    .data_val_o     (data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < q_bits.size(); i++) w[W-1-i] = q_bits[i];
    return w;
  endfunction

  task automatic emit(input logic [MW-1:0] m);
    exp_data = pack_bits();
    exp_mod  = m;
    exp_val  = 1'b1;
    exp_q.push_back({m, exp_data});
    q_bits.delete();
  endtask

  // Expected effect of one clock edge, from the burst rules.
  task automatic model_edge(input bit rst, input bit v, input bit d);
    exp_val = 1'b0;
    if (rst) begin
      q_bits.delete();
      exp_data = '0;
      exp_mod  = '0;
    end else if (v) begin
      q_bits.push_back(d);
      if (q_bits.size() == W) emit('0);
    end else if (q_bits.size() >= 3) begin
      emit(MW'(q_bits.size()));
    end else begin
      q_bits.delete();
    end
    exp_busy = (q_bits.size() != 0);
  endtask

  task automatic step(input bit rst, input bit v, input bit d);
    logic [W+MW-1:0] e;
    srst_i         = rst;
    ser_data_val_i = v;
    ser_data_i     = d;
    model_edge(rst, v, d);
    @(posedge clk);
    #1;
    chk("data_val", 32'(data_val_o), 32'(exp_val));
    chk("busy", 32'(busy_o), 32'(exp_busy));
    chk("data_hold", 32'(data_o), 32'(exp_data));
    if (data_val_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("pulse_data", 32'(data_o), 32'(e[W-1:0]));
        chk("pulse_mod", 32'(data_mod_o), 32'(e[W+MW-1:W]));
      end
    end
  endtask

  task automatic send_burst(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_data", 32'(data_o), 32'(0));
    chk("reset_mod", 32'(data_mod_o), 32'(0));
    idle(2);

    // Full word.
    send_burst(32'hA5C3, 16);
    idle(3);
    // Partial word of 5 bits.
    send_burst(32'b10110, 5);
    idle(3);
    // Illegal 2-bit burst, then minimum legal burst.
    send_burst(32'b11, 2);
    idle(3);
    send_burst(32'b111, 3);
    idle(3);
    // Continuous 32 bits split into two words.
    send_burst(32'hFFFF_1234, 32);
    idle(3);
    // Reset mid-burst, then a clean word.
    send_burst(32'h5A, 7);
    step(1'b1, 1'b0, 1'b0);
    chk("mid_reset_data", 32'(data_o), 32'(0));
    chk("mid_reset_busy", 32'(busy_o), 32'(0));
    send_burst(32'h8001, 16);
    idle(3);
    // One-cycle gap between two bursts.
    send_burst(32'hF0, 8);
    idle(1);
    send_burst(32'b1001, 4);
    idle(3);

    // Random bursts with short gaps and occasional resets.
    for (int b = 0; b < 120; b++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) step(1'b1, 1'b0, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(4);

    chk("pending_pulses", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
